// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered read data and a one-cycle valid pulse per accepted pop.
// Optional macro FIFO_ERR_EN adds sticky overflow/underflow flags.
module fifo_sync #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_push,
    input  logic             push,
    output logic             full,
    output logic [WIDTH-1:0] data_pop,
    output logic             valid,
    output logic             empty,
    input  logic             pop,
    output logic [AW:0]      count
`ifdef FIFO_ERR_EN
    ,
    output logic             overflow,
    output logic             underflow
`endif
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] data_pop_q, data_pop_d;
    logic             valid_q, valid_d;
    logic             push_acc, pop_acc;

    // Status decoded from registered pointers only; no path from push/pop.
    always_comb begin
        count = wr_ptr_q - rd_ptr_q;
        full  = (count == (AW+1)'(DEPTH));
        empty = (count == (AW+1)'(0));
    end

    assign push_acc = push & ~full;
    assign pop_acc  = pop & ~empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        data_pop_d = data_pop_q;
        valid_d    = 1'b0;
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop_acc) begin
            rd_ptr_d   = rd_ptr_q + (AW+1)'(1);
            data_pop_d = mem_q[rd_ptr_q[AW-1:0]];
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            data_pop_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            data_pop_q <= data_pop_d;
            valid_q    <= valid_d;
        end
    end

    // Storage array is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_push;
        end
    end

    assign data_pop = data_pop_q;
    assign valid    = valid_q;

`ifdef FIFO_ERR_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q | (push & full);
            underflow_q <= underflow_q | (pop & empty);
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// Randomized and directed bench for fifo_sync against a queue-based reference model.
module tb_fifo_sync;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] data_push;
    logic             push;
    logic             full;
    logic [WIDTH-1:0] data_pop;
    logic             valid;
    logic             empty;
    logic             pop;
    logic [AW:0]      count;
`ifdef FIFO_ERR_EN
    logic             overflow;
    logic             underflow;
`endif

    fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_push (data_push),
        .push      (push),
        .full      (full),
        .data_pop  (data_pop),
        .valid     (valid),
        .empty     (empty),
        .pop       (pop),
        .count     (count)
`ifdef FIFO_ERR_EN
        ,
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned      n_vec  = 0;
    int unsigned      n_miss = 0;
    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] exp_data;
    logic             exp_valid;
    logic             exp_ovf;
    logic             exp_unf;

    task automatic check_val(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_status();
        check_val("valid", WIDTH'(valid), WIDTH'(exp_valid));
        check_val("data_pop", data_pop, exp_data);
        check_val("count", WIDTH'(count), WIDTH'(model_q.size()));
        check_val("empty", WIDTH'(empty), WIDTH'(model_q.size() == 0));
        check_val("full", WIDTH'(full), WIDTH'(model_q.size() == DEPTH));
`ifdef FIFO_ERR_EN
        check_val("overflow", WIDTH'(overflow), WIDTH'(exp_ovf));
        check_val("underflow", WIDTH'(underflow), WIDTH'(exp_unf));
`endif
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
    endtask

    // One clock: drive request, let the edge happen, advance the model, compare.
    task automatic cycle(input logic p, input logic o, input logic [WIDTH-1:0] d);
        int unsigned occ;
        push      = p;
        pop       = o;
        data_push = d;
        @(posedge clk);
        #1;
        occ = model_q.size();
        if (p && occ == DEPTH) exp_ovf = 1'b1;
        if (o && occ == 0)     exp_unf = 1'b1;
        exp_valid = 1'b0;
        if (o && occ > 0) begin
            exp_data  = model_q.pop_front();
            exp_valid = 1'b1;
        end
        if (p && occ < DEPTH) model_q.push_back(d);
        push = 1'b0;
        pop  = 1'b0;
        check_status();
    endtask

    initial begin
        rst_n     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        data_push = '0;
        model_reset();
        #12;
        check_status();
        @(negedge clk);
        rst_n = 1'b1;

        // Fill, then overflow attempt
        for (int i = 1; i <= 16; i++) cycle(1'b1, 1'b0, WIDTH'(i));
        cycle(1'b1, 1'b0, 32'hDEAD);

        // Drain, then underflow attempt
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, '0);
        cycle(1'b0, 1'b1, '0);

        // Concurrent mid-occupancy, then concurrent when full
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, WIDTH'(32'h100 + i));
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, WIDTH'(32'h200 + i));
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, WIDTH'(32'h300 + i));
        cycle(1'b1, 1'b1, 32'hBAD0);
        // Concurrent when empty
        for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, '0);
        cycle(1'b1, 1'b1, 32'h55);
        cycle(1'b0, 1'b1, '0);

        // Wrap: 40-word stream, pop lagging push by one cycle
        for (int i = 0; i < 41; i++) cycle(i < 40, i > 0, WIDTH'(i));

        // Asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, WIDTH'(32'h400 + i));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_status();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 32'hAA);
        cycle(1'b0, 1'b1, '0);

        // Random traffic with biased push/pop rates
        for (int i = 0; i < 400; i++) begin
            int unsigned bias;
            bias = (i / 100) * 20 + 20;
            cycle($urandom_range(99) < bias, $urandom_range(99) < 100 - bias, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
